wave_display_mc: RTL and testbench

Multi-channel, parametrised waveform renderer for the VGA/HDMI pixel pipeline. It sits between the pixel timing generator and the sample RAMs, and overlays up to NUM_CH sampled waveforms in the top half of the screen inside a configurable x-window.
- Channel colours and vertical gain are programmable at run time.
- An optional graticule grid can be drawn.
- The RAM bank select is latched once per frame, so a bank swap never tears mid-frame.
- Pixel output is fully registered, with a fixed 2-cycle latency from x/y.

---
 rtl/wave_display_mc_if.sv | 37 +++
 rtl/wave_display_mc.sv | 155 +++++++++++++++
 tb/tb_wave_display_mc.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_display_mc_if.sv
// Pixel-pipeline bus for the multi-channel waveform renderer.
// Timing-side signals, sample-RAM port and registered pixel output.
interface wave_display_mc_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 9
);
  logic [10:0]              x;
  logic [9:0]               y;
  logic                     valid;
  logic                     read_index;
  logic [NUM_CH-1:0]        ch_enable;
  logic [24*NUM_CH-1:0]     ch_colors;
  logic [1:0]               scale_shift;
  logic [ADDR_W-1:0]        read_address;
  logic [SAMPLE_W*NUM_CH-1:0] read_values;
  logic                     valid_pixel;
  logic [7:0]               r;
  logic [7:0]               g;
  logic [7:0]               b;

  modport master (
    output x, y, valid, read_index,
    output ch_enable, ch_colors, scale_shift,
    output read_values,
    input  read_address,
    input  valid_pixel, r, g, b
  );

  modport slave (
    input  x, y, valid, read_index,
    input  ch_enable, ch_colors, scale_shift,
    input  read_values,
    output read_address,
    output valid_pixel, r, g, b
  );
endinterface

// File: rtl/wave_display_mc.sv
// Multi-channel waveform overlay renderer, 2-cycle x/y-to-pixel latency.
// Segments join consecutive samples; bank select latched at frame start.
module wave_display_mc #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 9,
  parameter int X_START  = 256,
  parameter int XSHIFT   = 1,
  parameter int Y_OFFSET = 32,
  parameter int GRID_EN  = 1
) (
  input  logic clk,
  input  logic reset,
  wave_display_mc_if.slave bus
);

  localparam int WIN_W = (1 << (ADDR_W - 1)) << XSHIFT;
  localparam logic [11:0] XS = 12'(X_START);
  localparam logic [11:0] XE = 12'(X_START + WIN_W);

  logic              bank_q;
  logic              win1_q;
  logic [7:0]        ypix1_q;
  logic [5:0]        lx1_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [ADDR_W-1:0] last_q;
  logic              pv_q;
  logic [7:0]        prev_q [NUM_CH];
  logic              vp_q;
  logic [23:0]       rgb_q;

  logic [11:0]       x_ext;
  logic [11:0]       lx_full;
  logic [11:0]       sidx;
  logic              in_win;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        cur [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic              upd;
  logic              grid;
  logic [23:0]       col_d;

  assign x_ext   = {1'b0, bus.x};
  assign lx_full = x_ext - XS;
  assign sidx    = lx_full >> XSHIFT;
  assign in_win  = bus.valid && !bus.y[9]
                && (x_ext >= XS) && (x_ext < XE);
  assign addr    = in_win ? {bank_q, sidx[ADDR_W-2:0]}
                          : '0;
  assign bus.read_address = addr;

  logic unused_ok;
  assign unused_ok = ^{bus.y[0], sidx[11:ADDR_W-1]};

  // Latch the RAM bank on the first visible pixel of a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= 1'b0;
    end else if (bus.valid && bus.x == 11'd0
                 && bus.y == 10'd0) begin
      bank_q <= bus.read_index;
    end
  end

  // Stage 1: pixel position held while the RAM read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      win1_q  <= 1'b0;
      ypix1_q <= '0;
      lx1_q   <= '0;
      addr1_q <= '0;
    end else begin
      win1_q  <= in_win;
      ypix1_q <= bus.y[8:1];
      lx1_q   <= lx_full[5:0];
      addr1_q <= addr;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SAMPLE_W-1:0] sv;
    logic [8:0]          sum;
    logic [7:0]          p;
    logic [7:0]          lo;
    logic [7:0]          hi;

    assign sv  = (bus.read_values[SAMPLE_W*c +: SAMPLE_W]
                 >> (SAMPLE_W - 8)) >> bus.scale_shift;
    assign sum = {1'b0, sv[7:0]} + 9'(Y_OFFSET);
    assign cur[c] = sum[8] ? 8'hFF : sum[7:0];
    assign p   = pv_q ? prev_q[c] : cur[c];
    assign lo  = (p < cur[c]) ? p : cur[c];
    assign hi  = (p < cur[c]) ? cur[c] : p;
    assign hit[c] = bus.ch_enable[c] && win1_q
                 && (ypix1_q >= lo) && (ypix1_q <= hi);

    if (SAMPLE_W > 8) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^sv[SAMPLE_W-1:8];
    end
  end

  assign upd  = win1_q && ((addr1_q != last_q) || !pv_q);
  assign grid = (GRID_EN != 0) && win1_q
             && ((lx1_q == 6'd0) || (ypix1_q[4:0] == 5'd0));

  // Lowest-index hit wins; grid only where no trace is drawn.
  always_comb begin
    col_d = 24'h000000;
    if (grid) begin
      col_d = 24'h404040;
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit[c]) begin
        col_d = bus.ch_colors[24*c +: 24];
      end
    end
  end

  // Remember each channel's last new sample to draw joining segments.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q   <= 1'b0;
      last_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        prev_q[c] <= '0;
      end
    end else if (!win1_q) begin
      pv_q <= 1'b0;
    end else if (upd) begin
      pv_q   <= 1'b1;
      last_q <= addr1_q;
      for (int c = 0; c < NUM_CH; c++) begin
        prev_q[c] <= cur[c];
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk) begin
    if (reset) begin
      vp_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      vp_q  <= win1_q;
      rgb_q <= col_d;
    end
  end

  assign bus.valid_pixel = vp_q;
  assign bus.r = rgb_q[23:16];
  assign bus.g = rgb_q[15:8];
  assign bus.b = rgb_q[7:0];

endmodule

// File: tb/tb_wave_display_mc.sv
// Scoreboard bench for wave_display_mc: a row-sweep driver with a
// behavioural pixel model, and a negedge monitor popping expectations.
module tb_wave_display_mc;

  localparam int NCH = 2;

  typedef struct {
    int          cyc;
    logic        vp;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wave_display_mc_if #(.NUM_CH(NCH), .SAMPLE_W(8), .ADDR_W(9)) bus ();

  wave_display_mc #(
    .NUM_CH(NCH), .SAMPLE_W(8), .ADDR_W(9), .X_START(256),
    .XSHIFT(1), .Y_OFFSET(32), .GRID_EN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0]  ram [NCH][512];
  logic [15:0] rv_q;
  always @(posedge clk)
    rv_q <= {ram[1][bus.read_address], ram[0][bus.read_address]};
  assign bus.read_values = rv_q;

  // reference model state
  bit          m_bank;
  bit          m_pv;
  int          m_last;
  int          m_prev [NCH];
  logic [1:0]  en;
  logic [23:0] colv [NCH];
  int          sc;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc + 2 != cyc || bus.valid_pixel !== e.vp
          || {bus.r, bus.g, bus.b} !== e.rgb) begin
        n_fail++;
        $display("FAIL pixel tag=%0d cyc=%0d got vp=%b rgb=%06h want vp=%b rgb=%06h",
                 e.cyc, cyc, bus.valid_pixel, {bus.r, bus.g, bus.b}, e.vp, e.rgb);
      end
    end
  end

  task automatic set_cfg(logic [1:0] e, logic [23:0] c0,
                         logic [23:0] c1, int s);
    en = e; colv[0] = c0; colv[1] = c1; sc = s;
    bus.ch_enable = e;
    bus.ch_colors = {c1, c0};
    bus.scale_shift = 2'(s);
  endtask

  task automatic fill(int ch, logic [7:0] v);
    for (int i = 0; i < 512; i++) ram[ch][i] = v;
  endtask

  task automatic issue(int x, int y, bit v);
    exp_t e;
    bit   inw;
    int   a, ea, yp, cur, p, lo, hi;
    bit   hitany;
    @(posedge clk);
    #1;
    bus.x = 11'(x);
    bus.y = 10'(y);
    bus.valid = v;
    inw = v && y < 512 && x >= 256 && x < 768;
    e.cyc = cyc;
    e.vp = inw;
    e.rgb = 24'h0;
    ea = 0;
    if (!inw) begin
      m_pv = 0;
    end else begin
      a = (int'(m_bank) * 256) + (x - 256) / 2;
      ea = a;
      yp = (y / 2) % 256;
      hitany = 0;
      if ((x - 256) % 64 == 0 || yp % 32 == 0) e.rgb = 24'h404040;
      for (int c = 0; c < NCH; c++) begin
        cur = (int'(ram[c][a]) >> sc) + 32;
        if (cur > 255) cur = 255;
        p = m_pv ? m_prev[c] : cur;
        lo = (p < cur) ? p : cur;
        hi = (p < cur) ? cur : p;
        if (!hitany && en[c] && yp >= lo && yp <= hi) begin
          hitany = 1;
          e.rgb = colv[c];
        end
      end
      if (!m_pv || a != m_last) begin
        m_pv = 1;
        m_last = a;
        for (int c = 0; c < NCH; c++) begin
          cur = (int'(ram[c][a]) >> sc) + 32;
          m_prev[c] = (cur > 255) ? 255 : cur;
        end
      end
    end
    q.push_back(e);
    if (v && x == 0 && y == 0) m_bank = bus.read_index;
    #1;
    n_chk++;
    if (bus.read_address !== 9'(ea)) begin
      n_fail++;
      $display("FAIL addr x=%0d y=%0d got %03h want %03h",
               x, y, bus.read_address, ea);
    end
  endtask

  task automatic row(int y, int drop_pct);
    repeat (2) issue(300, y, 0);
    for (int x = 240; x <= 790; x++)
      issue(x, y, $urandom_range(99) >= drop_pct);
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.valid = 1'b0;
    q.delete();
    m_bank = 0;
    m_pv = 0;
    m_last = 0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (bus.valid_pixel !== 1'b0 || {bus.r, bus.g, bus.b} !== 24'h0) begin
        n_fail++;
        $display("FAIL reset got vp=%b rgb=%06h want vp=0 rgb=000000",
                 bus.valid_pixel, {bus.r, bus.g, bus.b});
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.x = '0;
    bus.y = '0;
    bus.valid = 1'b0;
    bus.read_index = 1'b0;
    fill(0, 8'h40);
    fill(1, 8'h00);
    set_cfg(2'b01, 24'hFF0000, 24'h00FF00, 0);
    do_reset(3);

    // flat trace at ypix 96, then a grid-only row
    row(192, 0);
    row(200, 0);
    row(600, 0);

    // rising segment 48..128 between addresses 5 and 6
    fill(0, 8'h00);
    ram[0][5] = 8'h20;
    ram[0][6] = 8'hC0;
    set_cfg(2'b01, 24'hFF0000, 24'h00FF00, 1);
    row(94, 0);
    row(96, 0);
    row(256, 0);
    row(258, 0);

    // channel priority
    fill(0, 8'h40);
    fill(1, 8'h40);
    set_cfg(2'b11, 24'hFF0000, 24'h00FF00, 0);
    row(192, 0);
    set_cfg(2'b10, 24'hFF0000, 24'h00FF00, 0);
    row(192, 0);

    // bank switch only at frame start
    for (int i = 0; i < 512; i++) begin
      ram[0][i] = 8'($urandom);
      ram[1][i] = 8'($urandom);
    end
    set_cfg(2'b11, 24'h0000FF, 24'hFFFF00, 0);
    bus.read_index = 1'b1;
    row(100, 0);
    issue(0, 0, 1);
    row(100, 0);
    bus.read_index = 1'b0;
    issue(0, 0, 1);
    row(150, 5);

    // saturation, then reset mid-line
    fill(0, 8'hFF);
    set_cfg(2'b01, 24'h123456, 24'h00FF00, 0);
    row(510, 0);
    row(508, 0);
    bus.read_index = 1'b1;
    issue(0, 0, 1);
    for (int x = 250; x < 400; x++) issue(x, 510, 1);
    do_reset(1);
    bus.read_index = 1'b0;
    row(510, 0);

    // randomized rows
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 512; i++) begin
        ram[0][i] = 8'($urandom);
        ram[1][i] = 8'($urandom);
      end
      set_cfg(2'($urandom), 24'($urandom), 24'($urandom),
              $urandom_range(3));
      bus.read_index = 1'($urandom);
      if ($urandom_range(1) == 1) issue(0, 0, 1);
      row($urandom_range(1023), 10);
    end

    repeat (6) issue(300, 0, 0);
    repeat (4) @(negedge clk);
    n_chk++;
    if (q.size() > 1) begin
      n_fail++;
      $display("FAIL drain got %0d pending want <=1", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
